// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, instruction classes, opcodes, IR capture pattern.
package jtag_pkg;

  // 4-bit TAP state encoding (IEEE 1149.1 customary values)
  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_e;

  // Decoded instruction classes; every unknown opcode falls into BYPASS
  typedef enum logic [1:0] {
    INSTR_EXTEST,
    INSTR_IDCODE,
    INSTR_SAMPLE,
    INSTR_BYPASS
  } instr_e;

  // Opcode values, zero-extended to the IR width at the point of use
  localparam int OPC_EXTEST = 0;
  localparam int OPC_IDCODE = 1;
  localparam int OPC_SAMPLE = 2;

  // Low bits loaded into the IR shift stage on Capture-IR
  localparam logic [1:0] IR_CAPTURE = 2'b01;

  // Map a (zero-extended) IR value onto its instruction class
  function automatic instr_e decode_ir(input logic [31:0] ir);
    if (ir == 32'(OPC_EXTEST))      return INSTR_EXTEST;
    else if (ir == 32'(OPC_IDCODE)) return INSTR_IDCODE;
    else if (ir == 32'(OPC_SAMPLE)) return INSTR_SAMPLE;
    else                            return INSTR_BYPASS;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; emits one strobe per action state for the register file.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o,
  output logic tlr_o
);

  tap_state_e state_q, state_d;

  // Next state chosen by TMS from the current state
  always_comb begin
    state_d = state_q;
    case (state_q)
      TAP_RESET:      state_d = tms_i ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  state_d = tms_i ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   state_d = tms_i ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   state_d = tms_i ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   state_d = tms_i ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   state_d = tms_i ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  state_d = tms_i ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   state_d = tms_i ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   state_d = tms_i ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   state_d = tms_i ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   state_d = tms_i ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  state_d = tms_i ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        state_d = TAP_RESET;
    endcase
  end

  // State register, forced to Test-Logic-Reset by TRST_N
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TAP_RESET;
    else          state_q <= state_d;
  end

  // Strobes are true during the state whose action happens on the coming edge
  assign capture_dr_o = (state_q == TAP_CAPTURE_DR);
  assign shift_dr_o   = (state_q == TAP_SHIFT_DR);
  assign update_dr_o  = (state_q == TAP_UPDATE_DR);
  assign capture_ir_o = (state_q == TAP_CAPTURE_IR);
  assign shift_ir_o   = (state_q == TAP_SHIFT_IR);
  assign update_ir_o  = (state_q == TAP_UPDATE_IR);
  // Asserted on the edge that lands in (or stays in) Test-Logic-Reset, so the
  // logic reset is complete as soon as the controller arrives there.
  assign tlr_o        = (state_d == TAP_RESET);

endmodule

// File: rtl/jtag_boundary_scan_tap.sv
// TAP top: instruction register, IDCODE/bypass/boundary-scan registers and pin muxes.
module jtag_boundary_scan_tap
  import jtag_pkg::*;
#(
  parameter int          IN_W       = 34,
  parameter int          OUT_W      = 17,
  parameter int          IR_W       = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic             TCK,
  input  logic             TRST_N,
  input  logic             TMS,
  input  logic             TDI,
  output logic             TDO,
  output logic             TDO_EN,
  input  logic [IN_W-1:0]  sys_pin_in,
  output logic [IN_W-1:0]  module_pin_in,
  input  logic [OUT_W-1:0] module_pin_out,
  output logic [OUT_W-1:0] sys_pin_out
);

  localparam int L = IN_W + OUT_W;

  logic capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;
  logic tlr;

  jtag_tap_fsm u_fsm (
    .tck_i        (TCK),
    .trst_ni      (TRST_N),
    .tms_i        (TMS),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .tlr_o        (tlr)
  );

  logic [IR_W-1:0] ir_q, ir_sr_q;
  logic [L-1:0]    bsr_sr_q, bsr_upd_q;
  logic [31:0]     id_sr_q;
  logic            byp_q;
  instr_e          instr;
  logic            bsr_sel;

  assign instr   = decode_ir(32'(ir_q));
  assign bsr_sel = (instr == INSTR_EXTEST) || (instr == INSTR_SAMPLE);

  // Instruction register: capture pattern, shift toward TDO, commit on Update-IR
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_q    <= IR_W'(OPC_IDCODE);
      ir_sr_q <= '0;
    end else if (tlr) begin
      ir_q    <= IR_W'(OPC_IDCODE);
      ir_sr_q <= '0;
    end else begin
      if (capture_ir)    ir_sr_q <= IR_W'(IR_CAPTURE);
      else if (shift_ir) ir_sr_q <= {TDI, ir_sr_q[IR_W-1:1]};
      if (update_ir)     ir_q    <= ir_sr_q;
    end
  end

  // Data registers: only the register selected by the active instruction moves
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      bsr_sr_q  <= '0;
      bsr_upd_q <= '0;
      id_sr_q   <= '0;
      byp_q     <= 1'b0;
    end else if (tlr) begin
      bsr_sr_q  <= '0;
      bsr_upd_q <= '0;
      id_sr_q   <= '0;
      byp_q     <= 1'b0;
    end else begin
      if (capture_dr) begin
        case (instr)
          INSTR_IDCODE: id_sr_q  <= IDCODE_VAL;
          INSTR_BYPASS: byp_q    <= 1'b0;
          default:      bsr_sr_q <= {module_pin_out, sys_pin_in};
        endcase
      end else if (shift_dr) begin
        case (instr)
          INSTR_IDCODE: id_sr_q  <= {TDI, id_sr_q[31:1]};
          INSTR_BYPASS: byp_q    <= TDI;
          default:      bsr_sr_q <= {TDI, bsr_sr_q[L-1:1]};
        endcase
      end
      // Update latches only follow the chain for the two BSR instructions
      if (update_dr && bsr_sel) bsr_upd_q <= bsr_sr_q;
    end
  end

  // Serial output: bit 0 of whichever stage is shifting, low otherwise
  always_comb begin
    TDO = 1'b0;
    if (shift_ir) begin
      TDO = ir_sr_q[0];
    end else if (shift_dr) begin
      case (instr)
        INSTR_IDCODE: TDO = id_sr_q[0];
        INSTR_BYPASS: TDO = byp_q;
        default:      TDO = bsr_sr_q[0];
      endcase
    end
  end

  assign TDO_EN = shift_ir | shift_dr;

  // EXTEST drives both pin directions from the update latches; otherwise transparent
  assign module_pin_in = (instr == INSTR_EXTEST) ? bsr_upd_q[IN_W-1:0] : sys_pin_in;
  assign sys_pin_out   = (instr == INSTR_EXTEST) ? bsr_upd_q[L-1:IN_W] : module_pin_out;

endmodule
